fp_div: RTL and testbench

FP_DIV -- requirements
Module: fp_div

---
 rtl/fp_div_pkg.sv | 36 +++
 rtl/fp_class.sv | 33 +++
 rtl/fp_div.sv | 234 +++++++++++++++++++++++
 tb/tb_fp_div.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/fp_div_pkg.sv
// rtl/fp_div_pkg.sv - shared FP parameter set: flag indices, state encoding, exponent constants
package fp_div_pkg;

  // One-hot class flag bit positions shared by all FP units
  localparam int F_SNAN    = 0;
  localparam int F_QNAN    = 1;
  localparam int F_INF     = 2;
  localparam int F_ZERO    = 3;
  localparam int F_SUBNORM = 4;
  localparam int F_NORM    = 5;
  localparam int LAST_FLAG = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_PACK = 2'd2
  } fp_div_state_e;

  function automatic int fp_bias(input int n_exp);
    return (1 << (n_exp - 1)) - 1;
  endfunction

  function automatic int fp_emax(input int n_exp);
    return fp_bias(n_exp);
  endfunction

  function automatic int fp_emin(input int n_exp);
    return 1 - fp_bias(n_exp);
  endfunction

  // Smallest unbiased exponent that still yields a nonzero subnormal
  function automatic int fp_etiny(input int n_exp, input int n_sig);
    return fp_emin(n_exp) - n_sig;
  endfunction

endpackage

// File: rtl/fp_class.sv
// rtl/fp_class.sv - one-hot IEEE-754 class decode of an exponent/fraction pair
module fp_class
  import fp_div_pkg::*;
#(
  parameter int n_exp = 8,
  parameter int n_sig = 23
) (
  input  logic [n_exp+n_sig-1:0] x_i,
  output logic [LAST_FLAG-1:0]   cls_o
);

  logic [n_exp-1:0] exp_f;
  logic [n_sig-1:0] frac_f;

  assign exp_f  = x_i[n_exp+n_sig-1:n_sig];
  assign frac_f = x_i[n_sig-1:0];

  // All-ones exponent selects NaN/inf, all-zeros selects zero/subnormal
  always_comb begin
    cls_o = '0;
    if (&exp_f) begin
      if (frac_f == '0)          cls_o[F_INF]  = 1'b1;
      else if (frac_f[n_sig-1])  cls_o[F_QNAN] = 1'b1;
      else                       cls_o[F_SNAN] = 1'b1;
    end else if (exp_f == '0) begin
      if (frac_f == '0)          cls_o[F_ZERO]    = 1'b1;
      else                       cls_o[F_SUBNORM] = 1'b1;
    end else begin
      cls_o[F_NORM] = 1'b1;
    end
  end

endmodule

// File: rtl/fp_div.sv
// rtl/fp_div.sv - sequential restoring IEEE-754 divider; define FP_DIV_RNE_EN for round-to-nearest-even
module fp_div
  import fp_div_pkg::*;
#(
  parameter int n_exp = 8,
  parameter int n_sig = 23
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [n_exp+n_sig:0] a,
  input  logic [n_exp+n_sig:0] b,
  output logic                 ready,
  output logic                 done,
  output logic [n_exp+n_sig:0] q,
  output logic [LAST_FLAG-1:0] q_flags
);

  localparam int W  = n_exp + n_sig + 1;
  localparam int EW = n_exp + 2;
  localparam int SW = n_sig + 1;
  localparam int RW = n_sig + 2;
  localparam int QW = n_sig + 3;
  localparam int CW = $clog2(QW);
  localparam logic signed [EW-1:0] BIAS_S  = EW'(fp_bias(n_exp));
  localparam logic signed [EW-1:0] EMAX_S  = EW'(fp_emax(n_exp));
  localparam logic signed [EW-1:0] EMIN_S  = EW'(fp_emin(n_exp));
  localparam logic signed [EW-1:0] ETINY_S = EW'(fp_etiny(n_exp, n_sig));
  localparam logic [CW-1:0]        LAST_ITER = CW'(QW - 1);

  fp_div_state_e         state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [RW-1:0]         rem_q, rem_d;
  logic [SW-1:0]         div_q, div_d;
  logic [QW-1:0]         quot_q, quot_d;
  logic signed [EW-1:0]  ediff_q, ediff_d;
  logic                  sign_q, sign_d;
  logic                  spec_q, spec_d;
  logic [W-1:0]          spec_res_q, spec_res_d;
  logic [LAST_FLAG-1:0]  spec_flag_q, spec_flag_d;
  logic [W-1:0]          res_q, res_d;
  logic [LAST_FLAG-1:0]  flags_q, flags_d;
  logic                  done_q, done_d;

  logic [LAST_FLAG-1:0]  ca, cb;
  logic                  in_sign, a_zero, b_zero, sp_hit;
  logic [W-1:0]          sp_res;
  logic [LAST_FLAG-1:0]  sp_flag;

  logic                  step_ge;
  logic [RW-2:0]         step_sub;
  logic [RW-1:0]         step_rem;

  logic [SW-1:0]         sig_t, sig_r;
  logic [SW:0]           sig_rnd;
  logic                  guard, sticky, round_inc;
  logic signed [EW-1:0]  exp_t, exp_r, sub_sh;
  logic [W-1:0]          norm_res;
  logic [LAST_FLAG-1:0]  norm_flag;

  fp_class #(.n_exp(n_exp), .n_sig(n_sig)) u_class_a (.x_i(a[W-2:0]), .cls_o(ca));
  fp_class #(.n_exp(n_exp), .n_sig(n_sig)) u_class_b (.x_i(b[W-2:0]), .cls_o(cb));

  assign in_sign = a[W-1] ^ b[W-1];
  assign a_zero  = ca[F_ZERO] | ca[F_SUBNORM];
  assign b_zero  = cb[F_ZERO] | cb[F_SUBNORM];
  assign sp_hit  = ~(ca[F_NORM] & cb[F_NORM]);

  // Special-operand result in priority order; only used when sp_hit is set
  always_comb begin
    sp_res  = '0;
    sp_flag = '0;
    if (ca[F_SNAN]) begin
      sp_res = a; sp_flag[F_SNAN] = 1'b1;
    end else if (cb[F_SNAN]) begin
      sp_res = b; sp_flag[F_SNAN] = 1'b1;
    end else if (ca[F_QNAN]) begin
      sp_res = a; sp_flag[F_QNAN] = 1'b1;
    end else if (cb[F_QNAN]) begin
      sp_res = b; sp_flag[F_QNAN] = 1'b1;
    end else if ((ca[F_INF] && cb[F_INF]) || (a_zero && b_zero)) begin
      sp_res = {in_sign, {n_exp{1'b1}}, 1'b1, {(n_sig-1){1'b0}}};
      sp_flag[F_QNAN] = 1'b1;
    end else if (ca[F_INF] || b_zero) begin
      sp_res = {in_sign, {n_exp{1'b1}}, {n_sig{1'b0}}};
      sp_flag[F_INF] = 1'b1;
    end else begin
      sp_res = {in_sign, {(W-1){1'b0}}};
      sp_flag[F_ZERO] = 1'b1;
    end
  end

  // One restoring step: subtract divisor when it fits, then shift the remainder up
  always_comb begin
    step_ge  = rem_q >= {1'b0, div_q};
    step_sub = step_ge ? (RW-1)'(rem_q - {1'b0, div_q}) : rem_q[RW-2:0];
    step_rem = {step_sub, 1'b0};
  end

  // Normalise the quotient and extract guard/sticky
  always_comb begin
    if (quot_q[QW-1]) begin
      sig_t  = quot_q[QW-1:2];
      guard  = quot_q[1];
      sticky = quot_q[0] | (|rem_q);
      exp_t  = ediff_q;
    end else begin
      sig_t  = quot_q[QW-2:1];
      guard  = quot_q[0];
      sticky = |rem_q;
      exp_t  = ediff_q - EW'(1);
    end
  end

`ifdef FP_DIV_RNE_EN
  assign round_inc = guard & (sticky | sig_t[0]);
`else
  logic unused_grs;
  assign round_inc  = 1'b0;
  assign unused_grs = guard ^ sticky;
`endif

  // Round, then map the exponent onto inf / normal / subnormal / zero
  always_comb begin
    sig_rnd = {1'b0, sig_t} + {{SW{1'b0}}, round_inc};
    if (sig_rnd[SW]) begin
      sig_r = {1'b1, {n_sig{1'b0}}};
      exp_r = exp_t + EW'(1);
    end else begin
      sig_r = sig_rnd[SW-1:0];
      exp_r = exp_t;
    end
    sub_sh    = EMIN_S - exp_r;
    norm_flag = '0;
    if (exp_r > EMAX_S) begin
      norm_res = {sign_q, {n_exp{1'b1}}, {n_sig{1'b0}}};
      norm_flag[F_INF] = 1'b1;
    end else if (exp_r >= EMIN_S) begin
      norm_res = {sign_q, n_exp'(exp_r + BIAS_S), sig_r[n_sig-1:0]};
      norm_flag[F_NORM] = 1'b1;
    end else if (exp_r >= ETINY_S) begin
      norm_res = {sign_q, {n_exp{1'b0}}, n_sig'(sig_r >> sub_sh)};
      norm_flag[F_SUBNORM] = 1'b1;
    end else begin
      norm_res = {sign_q, {(W-1){1'b0}}};
      norm_flag[F_ZERO] = 1'b1;
    end
  end

  // Next-state and datapath updates for IDLE/CALC/PACK
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    div_d       = div_q;
    quot_d      = quot_q;
    ediff_d     = ediff_q;
    sign_d      = sign_q;
    spec_d      = spec_q;
    spec_res_d  = spec_res_q;
    spec_flag_d = spec_flag_q;
    res_d       = res_q;
    flags_d     = flags_q;
    done_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sign_d      = in_sign;
          ediff_d     = $signed({2'b00, a[W-2:n_sig]}) - $signed({2'b00, b[W-2:n_sig]});
          rem_d       = {1'b0, 1'b1, a[n_sig-1:0]};
          div_d       = {1'b1, b[n_sig-1:0]};
          quot_d      = '0;
          cnt_d       = '0;
          spec_d      = sp_hit;
          spec_res_d  = sp_res;
          spec_flag_d = sp_flag;
          state_d     = sp_hit ? ST_PACK : ST_CALC;
        end
      end
      ST_CALC: begin
        rem_d  = step_rem;
        quot_d = {quot_q[QW-2:0], step_ge};
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST_ITER) state_d = ST_PACK;
      end
      ST_PACK: begin
        res_d   = spec_q ? spec_res_q  : norm_res;
        flags_d = spec_q ? spec_flag_q : norm_flag;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Register update; reset aborts any operation in flight and clears the result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      div_q       <= '0;
      quot_q      <= '0;
      ediff_q     <= '0;
      sign_q      <= 1'b0;
      spec_q      <= 1'b0;
      spec_res_q  <= '0;
      spec_flag_q <= '0;
      res_q       <= '0;
      flags_q     <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      div_q       <= div_d;
      quot_q      <= quot_d;
      ediff_q     <= ediff_d;
      sign_q      <= sign_d;
      spec_q      <= spec_d;
      spec_res_q  <= spec_res_d;
      spec_flag_q <= spec_flag_d;
      res_q       <= res_d;
      flags_q     <= flags_d;
      done_q      <= done_d;
    end
  end

  assign ready   = (state_q == ST_IDLE);
  assign done    = done_q;
  assign q       = res_q;
  assign q_flags = flags_q;

endmodule

// File: tb/tb_fp_div.sv
// tb/tb_fp_div.sv - self-checking bench for fp_div (n_exp=8, n_sig=23), honours FP_DIV_RNE_EN
module tb_fp_div;

  localparam logic [5:0] FL_SNAN = 6'b000001;
  localparam logic [5:0] FL_QNAN = 6'b000010;
  localparam logic [5:0] FL_INF  = 6'b000100;
  localparam logic [5:0] FL_ZERO = 6'b001000;
  localparam logic [5:0] FL_SUB  = 6'b010000;
  localparam logic [5:0] FL_NORM = 6'b100000;
`ifdef FP_DIV_RNE_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [5:0]  fl;
    int          lat;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        ready;
  logic        done;
  logic [31:0] q;
  logic [5:0]  q_flags;

  int passed = 0;
  int total  = 0;
  vec_t tbl[16];

  fp_div #(.n_exp(8), .n_sig(23)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .ready(ready), .done(done), .q(q), .q_flags(q_flags)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // 0 snan, 1 qnan, 2 inf, 3 zero (subnormal included), 5 normal
  function automatic int kind(input logic [31:0] v);
    if (v[30:23] == 8'hFF) return (v[22:0] == '0) ? 2 : (v[22] ? 1 : 0);
    if (v[30:23] == 8'h00) return 3;
    return 5;
  endfunction

  // Exact division in integers, then the rounding and range rules
  function automatic void model(input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] r, output logic [5:0] fl, output int lat);
    logic s;
    int kx, ky, e;
    longint ma, mb, num, sv, rm;
    s = x[31] ^ y[31];
    kx = kind(x);
    ky = kind(y);
    lat = 2;
    if (kx == 0)                                      begin r = x; fl = FL_SNAN; end
    else if (ky == 0)                                 begin r = y; fl = FL_SNAN; end
    else if (kx == 1)                                 begin r = x; fl = FL_QNAN; end
    else if (ky == 1)                                 begin r = y; fl = FL_QNAN; end
    else if ((kx == 2 && ky == 2) || (kx == 3 && ky == 3)) begin r = {s, 8'hFF, 1'b1, 22'h0}; fl = FL_QNAN; end
    else if (kx == 2 || ky == 3)                      begin r = {s, 8'hFF, 23'h0}; fl = FL_INF; end
    else if (kx == 3 || ky == 2)                      begin r = {s, 31'h0}; fl = FL_ZERO; end
    else begin
      lat = 28;
      ma = longint'({1'b1, x[22:0]});
      mb = longint'({1'b1, y[22:0]});
      e  = int'(x[30:23]) - int'(y[30:23]);
      if (ma < mb) begin e = e - 1; num = ma << 24; end
      else num = ma << 23;
      sv = num / mb;
      rm = num % mb;
      if (RNE && ((2 * rm > mb) || (2 * rm == mb && sv[0]))) sv = sv + 1;
      if (sv == (longint'(1) << 24)) begin sv = longint'(1) << 23; e = e + 1; end
      if (e > 127)        begin r = {s, 8'hFF, 23'h0}; fl = FL_INF; end
      else if (e >= -126) begin r = {s, 8'(e + 127), sv[22:0]}; fl = FL_NORM; end
      else if (e >= -149) begin r = {s, 8'h00, 23'(sv >> (-126 - e))}; fl = FL_SUB; end
      else                begin r = {s, 31'h0}; fl = FL_ZERO; end
    end
  endfunction

  function automatic logic [31:0] rand_op();
    logic [7:0]  e;
    logic [22:0] f;
    case ($urandom_range(0, 15))
      0:       e = 8'h00;
      1:       e = 8'hFF;
      2:       e = 8'($urandom_range(1, 20));
      3:       e = 8'($urandom_range(235, 254));
      default: e = 8'($urandom_range(1, 254));
    endcase
    f = 23'($urandom);
    if ($urandom_range(0, 7) == 0) f = '0;
    return {1'($urandom), e, f};
  endfunction

  // Issue one operation and wait (bounded) for done; lat=0 flags a timeout
  task automatic do_op(input logic [31:0] av, input logic [31:0] bv,
                       output logic [31:0] qv, output logic [5:0] fv, output int lat);
    int w;
    @(negedge clk);
    w = 0;
    while (!ready && w < 100) begin @(negedge clk); w++; end
    a = av; b = bv; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0; qv = '0; fv = '0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (done) begin lat = i; qv = q; fv = q_flags; break; end
    end
  endtask

  initial begin
    logic [31:0] qv, eq;
    logic [5:0]  fv, ef;
    int          lat, elat, cyc;
    bit          saw;

    tbl[0]  = '{32'h40C00000, 32'h40000000, 32'h40400000, FL_NORM, 28};
    tbl[1]  = '{32'h3F800000, 32'h40400000, RNE ? 32'h3EAAAAAB : 32'h3EAAAAAA, FL_NORM, 28};
    tbl[2]  = '{32'h3F800000, 32'h00000000, 32'h7F800000, FL_INF, 2};
    tbl[3]  = '{32'h00000000, 32'h00000000, 32'h7FC00000, FL_QNAN, 2};
    tbl[4]  = '{32'h7F800001, 32'h7FC00000, 32'h7F800001, FL_SNAN, 2};
    tbl[5]  = '{32'h7F000000, 32'h3E800000, 32'h7F800000, FL_INF, 28};
    tbl[6]  = '{32'hC0C00000, 32'h40000000, 32'hC0400000, FL_NORM, 28};
    tbl[7]  = '{32'h7FC00000, 32'h7F800001, 32'h7F800001, FL_SNAN, 2};
    tbl[8]  = '{32'h7F800000, 32'hFF800000, 32'hFFC00000, FL_QNAN, 2};
    tbl[9]  = '{32'h3F800000, 32'h7F800000, 32'h00000000, FL_ZERO, 2};
    tbl[10] = '{32'h00000001, 32'h3F800000, 32'h00000000, FL_ZERO, 2};
    tbl[11] = '{32'h3F800000, 32'h80000001, 32'hFF800000, FL_INF, 2};
    tbl[12] = '{32'h00800000, 32'h40000000, 32'h00400000, FL_SUB, 28};
    tbl[13] = '{32'h00800000, 32'h4B800000, 32'h00000000, FL_ZERO, 28};
    tbl[14] = '{32'h3F800000, 32'hBF800000, 32'hBF800000, FL_NORM, 28};
    tbl[15] = '{32'h7FC00001, 32'h3F800000, 32'h7FC00001, FL_QNAN, 2};

    repeat (3) @(negedge clk);
    check("reset ready", 32'(ready), 32'd1);
    check("reset done", 32'(done), 32'd0);
    check("reset q", q, 32'h0);
    check("reset flags", 32'(q_flags), 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      do_op(tbl[i].a, tbl[i].b, qv, fv, lat);
      check($sformatf("tbl%0d q", i), qv, tbl[i].q);
      check($sformatf("tbl%0d flags", i), 32'(fv), 32'(tbl[i].fl));
      check($sformatf("tbl%0d latency", i), 32'(lat), 32'(tbl[i].lat));
    end

    for (int i = 0; i < 250; i++) begin
      logic [31:0] ra, rb;
      ra = rand_op();
      rb = rand_op();
      model(ra, rb, eq, ef, elat);
      do_op(ra, rb, qv, fv, lat);
      check($sformatf("rnd%0d %h/%h q", i, ra, rb), qv, eq);
      check($sformatf("rnd%0d flags", i), 32'(fv), 32'(ef));
      check($sformatf("rnd%0d latency", i), 32'(lat), 32'(elat));
      check($sformatf("rnd%0d onehot", i), 32'($countones(fv)), 32'd1);
    end

    // start while busy is ignored
    @(negedge clk);
    a = 32'h40C00000; b = 32'h40000000; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    a = 32'h0; b = 32'h0; start = 1'b1;
    check("busy ready", 32'(ready), 32'd0);
    @(negedge clk);
    start = 1'b0;
    cyc = 6; qv = '0; fv = '0; lat = 0;
    while (cyc < 100 && lat == 0) begin
      @(negedge clk);
      cyc++;
      if (done) begin lat = cyc; qv = q; fv = q_flags; end
    end
    check("busy q", qv, 32'h40400000);
    check("busy flags", 32'(fv), 32'(FL_NORM));
    check("busy latency", 32'(lat), 32'd28);

    // reset in the middle of CALC
    @(negedge clk);
    a = 32'h3F800000; b = 32'h40400000; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (6) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort ready", 32'(ready), 32'd1);
    check("abort done", 32'(done), 32'd0);
    check("abort q", q, 32'h0);
    check("abort flags", 32'(q_flags), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    saw = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) saw = 1'b1;
    end
    check("abort no done", 32'(saw), 32'd0);

    do_op(tbl[0].a, tbl[0].b, qv, fv, lat);
    check("recover q", qv, tbl[0].q);
    check("recover latency", 32'(lat), 32'd28);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
